// File: rtl/id_ex_if.sv
// Decode/execute bundle interface.
// Carries one valid/ready handshake together with the decoded bundle.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. While valid is 1, the master holds the data stable.
// ready is a registered output of the buffer, so it never depends on valid
// combinationally.
//
// Signals:
//   valid      bundle valid (master -> slave)
//   ready      slave accepts this cycle (slave -> master)
//   inst       instruction word, XLEN bits
//   inst_addr  instruction address, XLEN bits
//   op1, op2   operands, XLEN bits
//   rd_addr    destination register, 5 bits
//   reg_wen    write-back enable
interface id_ex_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd_addr;
    logic            reg_wen;

    modport master (
        output valid, inst, inst_addr, op1, op2, rd_addr, reg_wen,
        input  ready
    );

    modport slave (
        input  valid, inst, inst_addr, op1, op2, rd_addr, reg_wen,
        output ready
    );
endinterface

// File: rtl/id_ex_buf.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer.
// MAIN drives the execute side. SKID catches one bundle while MAIN is stalled.
// A flush from execute drops both entries.
//
// Ports:
//   clk       clock. All state changes on the rising edge.
//   rst_n     asynchronous active-low reset.
//   flush_i   squash all held entries (taken branch/jump).
//   in_bus    slave side. The decode stage offers bundles here. ready = ~skid_valid.
//   out_bus   master side. Bundles go to execute. The NOP bundle is shown while empty.
module id_ex_buf #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = 'h00000013
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush_i,
    id_ex_if.slave  in_bus,
    id_ex_if.master out_bus
);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] inst_addr;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      rd_addr;
        logic            reg_wen;
    } bundle_t;

    bundle_t main_q;
    bundle_t skid_q;
    bundle_t in_b;
    logic    main_valid;
    logic    skid_valid;
    logic    accept;
    logic    consume;

    assign in_b = '{inst:      in_bus.inst,
                    inst_addr: in_bus.inst_addr,
                    op1:       in_bus.op1,
                    op2:       in_bus.op2,
                    rd_addr:   in_bus.rd_addr,
                    reg_wen:   in_bus.reg_wen};

    // skid_valid is a flop, so ready is registered. It does not depend on
    // out_bus.ready.
    assign in_bus.ready = ~skid_valid;
    assign accept       = in_bus.valid & ~skid_valid;
    assign consume      = main_valid & out_bus.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush_i) begin
            // Anything accepted in the flush cycle is dropped as well.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || consume) begin
            if (skid_valid) begin
                // The older bundle moves up first to keep arrival order.
                main_valid <= 1'b1;
                main_q     <= skid_q;
                skid_valid <= accept;
                if (accept) begin
                    skid_q <= in_b;
                end
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= in_b;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_q     <= in_b;
        end
    end

    // While MAIN is empty the output shows the NOP bundle. Reset clears
    // main_valid asynchronously, so the NOP bundle appears as soon as rst_n
    // falls.
    always_comb begin
        out_bus.valid     = main_valid;
        out_bus.inst      = NOP_INST;
        out_bus.inst_addr = '0;
        out_bus.op1       = '0;
        out_bus.op2       = '0;
        out_bus.rd_addr   = '0;
        out_bus.reg_wen   = 1'b0;
        if (main_valid) begin
            out_bus.inst      = main_q.inst;
            out_bus.inst_addr = main_q.inst_addr;
            out_bus.op1       = main_q.op1;
            out_bus.op2       = main_q.op2;
            out_bus.rd_addr   = main_q.rd_addr;
            out_bus.reg_wen   = main_q.reg_wen;
        end
    end

endmodule
